// File: rtl/dual_rail_vector_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : dual_rail_vector_driver_if
//  Description : Bundle between the dual-rail vector driver and its
//                environment: sweep control, the eight rails driven into the
//                cell under test, the cell output and the sweep status.
//                The FIRST_FAIL_EN macro adds the first-failure report.
//  Revision    : 1.0  initial release
// ============================================================================
interface dual_rail_vector_driver_if;
    logic       start;
    logic       a;
    logic       an;
    logic       b;
    logic       bn;
    logic       c;
    logic       cn;
    logic       d;
    logic       dn;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_cnt;
    logic [3:0] vec_idx;
`ifdef FIRST_FAIL_EN
    logic [3:0] first_fail_idx;
    logic [0:0] first_fail_vld;
`endif

    // Driver side: produces the rails and the status, consumes start and
    // the output of the cell.
    modport master (
        input  start,
        input  dut_out,
        output a, an, b, bn, c, cn, d, dn,
        output busy,
        output done,
        output pass,
        output err_cnt,
`ifdef FIRST_FAIL_EN
        output first_fail_idx,
        output first_fail_vld,
`endif
        output vec_idx
    );

    // Environment side: the cell model and the sweep controller.
    modport slave (
        output start,
        output dut_out,
        input  a, an, b, bn, c, cn, d, dn,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
`ifdef FIRST_FAIL_EN
        input  first_fail_idx,
        input  first_fail_vld,
`endif
        input  vec_idx
    );
endinterface
`default_nettype wire

// File: rtl/dual_rail_vector_driver.sv
`default_nettype none
// ============================================================================
//  Module      : dual_rail_vector_driver
//  Description : Exhaustive dual-rail stimulus engine for a 4-input
//                complementary gate cell. Walks vectors 0..15, separating
//                each with an all-rails-low spacer, samples the cell output
//                after a settle time and counts mismatches against TRUTH.
//                Optional macro FIRST_FAIL_EN records the first failing
//                vector of each sweep.
//  Revision    : 1.0  initial release
// ============================================================================
module dual_rail_vector_driver #(
    parameter logic [15:0] TRUTH         = 16'h0000,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned NULL_CYCLES   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    dual_rail_vector_driver_if.master bus
);

    // Phase lengths as loaded into the shared 8-bit phase counter.
    localparam logic [7:0] c_null_load   = 8'(NULL_CYCLES);
    localparam logic [7:0] c_settle_load = 8'(SETTLE_CYCLES);
    localparam logic [7:0] c_sample_load = 8'd1;
    localparam logic [3:0] c_last_vec    = 4'd15;
    localparam logic [4:0] c_err_max     = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NULL   = 3'd1,
        ST_DATA   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_phase_cnt;
    logic [7:0] w_phase_load;
    logic       w_phase_end;
    logic       w_accept;
    logic       w_mismatch;
    logic [3:0] r_vec_idx;
    logic [4:0] r_err_cnt;
    logic [7:0] r_rails;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic       w_rails_data;
    logic       w_in_sweep;

    // A sweep may only be launched from the two resting states.
    assign w_accept    = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_phase_end = (r_phase_cnt == 8'd1);

    // Case-inequality so an unknown or floating cell output is a failure.
    assign w_mismatch  = (r_state == ST_SAMPLE) && (bus.dut_out !== TRUTH[r_vec_idx]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and the phase length loaded on entry to that state.
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_load = 8'd0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_NULL;
                end
            end
            ST_NULL: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (r_vec_idx == c_last_vec) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_NULL;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = ST_NULL;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        unique case (w_state_nxt)
            ST_NULL:   w_phase_load = c_null_load;
            ST_DATA:   w_phase_load = c_settle_load;
            ST_SAMPLE: w_phase_load = c_sample_load;
            default:   w_phase_load = 8'd0;
        endcase
    end

    // Phase down-counter: reloaded whenever the state changes, otherwise
    // counts down; a phase is over when it reads 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase_cnt <= 8'd0;
        end else if (w_state_nxt != r_state) begin
            r_phase_cnt <= w_phase_load;
        end else if (r_phase_cnt != 8'd0) begin
            r_phase_cnt <= r_phase_cnt - 8'd1;
        end
    end

    // Vector index and saturating error count; cleared when a sweep starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec_idx <= 4'd0;
            r_err_cnt <= 5'd0;
        end else if (w_accept) begin
            r_vec_idx <= 4'd0;
            r_err_cnt <= 5'd0;
        end else if (r_state == ST_SAMPLE) begin
            if (w_mismatch && (r_err_cnt != c_err_max)) begin
                r_err_cnt <= r_err_cnt + 5'd1;
            end
            if (r_vec_idx != c_last_vec) begin
                r_vec_idx <= r_vec_idx + 4'd1;
            end
        end
    end

`ifdef FIRST_FAIL_EN
    logic [3:0] r_first_fail_idx;
    logic       r_first_fail_vld;

    // Capture only the first mismatching vector of each sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_fail_idx <= 4'd0;
            r_first_fail_vld <= 1'b0;
        end else if (w_accept) begin
            r_first_fail_idx <= 4'd0;
            r_first_fail_vld <= 1'b0;
        end else if (w_mismatch && !r_first_fail_vld) begin
            r_first_fail_idx <= r_vec_idx;
            r_first_fail_vld <= 1'b1;
        end
    end

    assign bus.first_fail_idx = r_first_fail_idx;
    assign bus.first_fail_vld = r_first_fail_vld;
`endif

    // The vector stays on the rails through the settle phase and the sample
    // cycle; every other state drives the all-low spacer.
    assign w_rails_data = (r_state == ST_DATA) || (r_state == ST_SAMPLE);
    assign w_in_sweep   = (r_state == ST_NULL) || w_rails_data;

    // Registered rails and status, derived from the current state so every
    // output toggles only on a clock edge and no pair can ever read 1/1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rails <= 8'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            if (w_rails_data) begin
                r_rails <= { r_vec_idx[3], ~r_vec_idx[3],
                             r_vec_idx[2], ~r_vec_idx[2],
                             r_vec_idx[1], ~r_vec_idx[1],
                             r_vec_idx[0], ~r_vec_idx[0] };
            end else begin
                r_rails <= 8'd0;
            end
            r_busy <= w_in_sweep;
            r_done <= (r_state == ST_DONE);
            r_pass <= (r_state == ST_DONE) && (r_err_cnt == 5'd0);
        end
    end

    assign bus.a       = r_rails[7];
    assign bus.an      = r_rails[6];
    assign bus.b       = r_rails[5];
    assign bus.bn      = r_rails[4];
    assign bus.c       = r_rails[3];
    assign bus.cn      = r_rails[2];
    assign bus.d       = r_rails[1];
    assign bus.dn      = r_rails[0];
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.pass    = r_pass;
    assign bus.err_cnt = r_err_cnt;
    assign bus.vec_idx = r_vec_idx;

endmodule
`default_nettype wire
